pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
- REQ-001: Parameter PC_W, default 9, sets the width of the PC register and the instruction-memory address.
- REQ-002: Parameter CNT_W, default 16, sets the width of the redirect counter.
- REQ-003: clk  in  1  single clock; all state updates on the rising edge.
- REQ-004: reset  in  1  synchronous, active-high reset.
- REQ-005: PcSel  in  1  redirect request from the branch/jump resolution stage (1 = taken).
- REQ-006: BrPC  in  32  redirect target; bits [31:PC_W] are ignored.
- REQ-007: Halt  in  1  halt request from the execute stage.
- REQ-008: Stall  in  1  load-use hazard stall from the hazard unit.
- REQ-009: Cur_PC  out  PC_W  current fetch address, driven from a register.
- REQ-010: Fetch_Valid  out  1  the instruction fetched at Cur_PC this cycle is to be used.
- REQ-011: Flush_IFID  out  1  squash the IF/ID pipeline register.
- REQ-012: Flush_IDEX  out  1  squash the ID/EX pipeline register.
- REQ-013: Halted  out  1  the core is in the halted state.
- REQ-014: Redirect_Cnt  out  CNT_W  saturating count of accepted redirects.
- REQ-015: Misalign_Err  out  1  sticky flag for a misaligned redirect target.

Function
- REQ-016: The FSM SHALL have three states: RUN, BUBBLE and HALT.
- REQ-017: Next-PC priority in RUN and BUBBLE SHALL be, highest first:
  - redirect: PcSel=1, next PC = BrPC[PC_W-1:0];
  - Halt=1: PC held;
  - Stall=1: PC held;
  - otherwise: PC + 4.
- REQ-018: PC + 4 SHALL wrap modulo 2^PC_W, so that 2^PC_W-4 is followed by 0.
- REQ-019: Flush_IFID and Flush_IDEX SHALL equal PcSel combinationally in RUN and BUBBLE, and SHALL be 0 in HALT.
- REQ-020: An accepted redirect SHALL move the FSM to BUBBLE for exactly one cycle.
  - Fetch_Valid=0 while in BUBBLE.
  - The FSM then returns to RUN.
- REQ-021: A redirect while in BUBBLE SHALL be accepted and the FSM SHALL stay in BUBBLE one more cycle.
- REQ-022: Fetch_Valid SHALL be 1 in RUN, including during Stall, where the same instruction is re-presented.
- REQ-023: Halt=1 with PcSel=0 SHALL move the FSM to HALT; Halt=1 together with PcSel=1 SHALL take the redirect only.
- REQ-024: In HALT, the following SHALL hold until reset:
  - Cur_PC held;
  - Fetch_Valid=0;
  - Halted=1;
  - all inputs ignored.
- REQ-025: Redirect_Cnt SHALL increment on each accepted redirect and SHALL saturate at 2^CNT_W-1.
- REQ-026: Stall and PcSel asserted together SHALL resolve as a redirect; Stall is ignored that cycle.

Reset
- REQ-027: Reset SHALL have priority over all inputs and SHALL set:
  - Cur_PC=0, state RUN;
  - Redirect_Cnt=0, Misalign_Err=0.
- REQ-028: While reset=1, the outputs SHALL be Fetch_Valid=0, both flush outputs 0 and Halted=0.
- REQ-029: Asserting reset while in BUBBLE or HALT SHALL return the block to RUN at PC 0 on the next edge.

Configuration
- REQ-030: Macro PC_MISALIGN_TRAP_EN, when defined, SHALL treat a redirect with BrPC[1:0]!=0 as follows:
  - the redirect is not taken and Redirect_Cnt is unchanged;
  - flushes are still asserted;
  - the FSM moves to HALT with Misalign_Err set to 1.
- REQ-031: Without PC_MISALIGN_TRAP_EN, BrPC[1:0] SHALL be forced to 00 on redirect and Misalign_Err SHALL be tied to 0.
- REQ-032: The Misalign_Err port SHALL exist in both configurations.

Structure
- REQ-033: The shared pipeline package SHALL hold:
  - the fetch_state_t enum (RUN, BUBBLE, HALT);
  - the default PC_W and CNT_W constants;
  - the constant PC_INCR = 4.
- REQ-034: The saturating counter SHALL be a sub-module named sat_counter, parameterized by width.

Verification
- REQ-035: Reset, then 4 cycles idle -> Cur_PC sequence 0, 4, 8, 12; Fetch_Valid=1 after reset.
- REQ-036: PcSel=1 with BrPC=0x40 at PC 8 -> both flushes high that cycle, next Cur_PC=0x40 with Fetch_Valid=0, then 0x44 with Fetch_Valid=1; Redirect_Cnt=1.
- REQ-037: Stall=1 for 2 cycles at PC 12 -> Cur_PC stays 12 for 2 cycles; Stall and PcSel together with BrPC=0x80 -> Cur_PC=0x80.
- REQ-038: PC_W=9 at PC 508 with no stall -> next Cur_PC=0; BrPC=0x1234 -> Cur_PC=0x034.
- REQ-039: Halt and PcSel together (BrPC=0x20), then Halt alone -> Cur_PC=0x20, then HALT with Halted=1; further PcSel pulses are ignored; reset -> Cur_PC=0 and Halted=0.
- REQ-040: Misaligned target with BrPC=0x22:
  - with PC_MISALIGN_TRAP_EN defined -> Misalign_Err=1, Halted=1, PC unchanged;
  - without it -> Cur_PC=0x20 and Misalign_Err=0.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl_pkg
// Description : Shared fetch-stage types and constants (FSM states, default
//               widths, sequential PC increment).
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_ctrl_pkg;

    localparam int unsigned PC_W_DEFAULT  = 9;
    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned PC_INCR       = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } fetch_state_t;

endpackage : pc_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/pc_fetch_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Fetch PC register with redirect/halt/stall control, pipeline
//               flush generation and a saturating redirect counter.
//               Optional macro PC_MISALIGN_TRAP_EN: misaligned redirect
//               targets halt the core and set Misalign_Err.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PcSel,
    input  logic [31:0]      BrPC,
    input  logic             Halt,
    input  logic             Stall,
    output logic [PC_W-1:0]  Cur_PC,
    output logic             Fetch_Valid,
    output logic             Flush_IFID,
    output logic             Flush_IDEX,
    output logic             Halted,
    output logic [CNT_W-1:0] Redirect_Cnt,
    output logic             Misalign_Err
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_active;
    logic            w_misalign;
    logic            w_redirect;
    logic            w_unused_brpc;

    // Targets are word aligned; upper bits beyond the fetch address are dropped.
    assign w_target      = {BrPC[PC_W-1:2], 2'b00};
    assign w_pc_inc      = r_pc + PC_W'(PC_INCR);
    assign w_unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};
    assign w_active      = (r_state != HALT);

`ifdef PC_MISALIGN_TRAP_EN
    logic r_misalign_err;

    assign w_misalign = w_active && PcSel && (BrPC[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign_err <= 1'b0;
        end else if (w_misalign) begin
            r_misalign_err <= 1'b1;
        end
    end

    assign Misalign_Err = r_misalign_err;
`else
    assign w_misalign   = 1'b0;
    assign Misalign_Err = 1'b0;
`endif

    assign w_redirect = w_active && PcSel && !w_misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        Fetch_Valid = 1'b0;
        Flush_IFID  = 1'b0;
        Flush_IDEX  = 1'b0;
        Halted      = 1'b0;

        if (w_active) begin
            if (w_redirect) begin
                w_pc_nxt    = w_target;
                w_state_nxt = BUBBLE;
            end else if (w_misalign || Halt) begin
                w_state_nxt = HALT;
            end else begin
                // BUBBLE always lasts one cycle; a stall only freezes the PC.
                w_state_nxt = RUN;
                if (!Stall) begin
                    w_pc_nxt = w_pc_inc;
                end
            end
        end

        if (!reset) begin
            Fetch_Valid = (r_state == RUN);
            Halted      = (r_state == HALT);
            Flush_IFID  = w_active && PcSel;
            Flush_IDEX  = w_active && PcSel;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_redirect_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_redirect),
        .o_count (Redirect_Cnt)
    );

    assign Cur_PC = r_pc;

endmodule : pc_fetch_ctrl
`default_nettype wire
